// File: rtl/weighted_referee_if.sv
// rtl/weighted_referee_if.sv - source/destination FIFO bundle between weighted_referee and its VC FIFO pairs
interface weighted_referee_if #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 12,
    parameter int WEIGHT_W = 4
);
    logic [NUM_CH-1:0]          src_empty;
    logic [NUM_CH-1:0]          src_almost_full;
    logic [NUM_CH-1:0]          dst_almost_full;
    logic [NUM_CH*WEIGHT_W-1:0] weights;
    logic [DATA_W-1:0]          data_in;
    logic [NUM_CH-1:0]          pop;
    logic [NUM_CH-1:0]          push;
    logic [DATA_W-1:0]          data_out;

    // referee side: issues pop/push strobes and carries the payload
    modport master (
        input  src_empty, src_almost_full, dst_almost_full, weights, data_in,
        output pop, push, data_out
    );

    // FIFO side: reports levels and supplies read data
    modport slave (
        output src_empty, src_almost_full, dst_almost_full, weights, data_in,
        input  pop, push, data_out
    );
endinterface

// File: rtl/weighted_referee.sv
// rtl/weighted_referee.sv - RR/weighted-RR mover between VC FIFO pairs; WEIGHTED_REFEREE_STATS_EN adds grant_count
module weighted_referee #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 12,
    parameter int WEIGHT_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    weighted_referee_if.master     bus
`ifdef WEIGHTED_REFEREE_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]   grant_count
`endif
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        RR  = 1'b0,
        WRR = 1'b1
    } mode_t;

    mode_t                state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]  credit_q, credit_d;
    logic [WEIGHT_W-1:0]  credit_eff;
    logic [WEIGHT_W-1:0]  w_cur;
    logic [NUM_CH-1:0]    pop_d, pop_q, push_q;
    logic [DATA_W-1:0]    data_q;
    logic                 stall;
    logic                 keep;
    logic                 found;
    logic [PTR_W-1:0]     sel;

    // Mode selection, rotating search and credit bookkeeping for the next pop
    always_comb begin
        state_d    = (|bus.src_almost_full) ? WRR : RR;
        ptr_d      = ptr_q;
        pop_d      = '0;
        stall      = |bus.dst_almost_full;
        // a mode change starts a fresh weighted run; credit 0 means "no run in progress"
        credit_eff = (state_d != state_q) ? '0 : credit_q;
        credit_d   = credit_eff;
        w_cur      = bus.weights[int'(ptr_q)*WEIGHT_W +: WEIGHT_W];
        if (w_cur == '0) begin
            w_cur = WEIGHT_W'(1);
        end
        keep  = (state_d == WRR) && (credit_eff != '0) && (credit_eff < w_cur)
                && !bus.src_empty[ptr_q];
        found = 1'b0;
        sel   = ptr_q;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!found && !bus.src_empty[(int'(ptr_q) + k) % NUM_CH]) begin
                found = 1'b1;
                sel   = PTR_W'((int'(ptr_q) + k) % NUM_CH);
            end
        end
        if (!stall) begin
            if (keep) begin
                pop_d[ptr_q] = 1'b1;
                credit_d     = credit_eff + WEIGHT_W'(1);
            end else if (found) begin
                pop_d[sel] = 1'b1;
                ptr_d      = sel;
                credit_d   = (state_d == WRR) ? WEIGHT_W'(1) : '0;
            end
        end
    end

    // Mode state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RR;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer, credit and registered strobes/payload; push trails pop by one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q    <= PTR_W'(NUM_CH - 1);
            credit_q <= '0;
            pop_q    <= '0;
            push_q   <= '0;
            data_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            pop_q    <= pop_d;
            push_q   <= pop_q;
            if (|pop_q) begin
                data_q <= bus.data_in;
            end
        end
    end

    assign bus.pop      = pop_q;
    assign bus.push     = push_q;
    assign bus.data_out = data_q;

`ifdef WEIGHTED_REFEREE_STATS_EN
    logic [15:0] cnt_q [NUM_CH];

    // Per-channel saturating counts of issued pops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (pop_q[i] && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign grant_count[g*16 +: 16] = cnt_q[g];
    end
`endif
endmodule

// File: tb/tb_weighted_referee.sv
// tb/tb_weighted_referee.sv - scoreboard bench for weighted_referee (RR, WRR, stall, empty, reset)
module tb_weighted_referee;
    localparam int NUM_CH   = 4;
    localparam int DATA_W   = 12;
    localparam int WEIGHT_W = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    weighted_referee_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W)) bus ();

`ifdef WEIGHTED_REFEREE_STATS_EN
    logic [NUM_CH*16-1:0] grant_count;
`endif

    weighted_referee #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .bus         (bus)
`ifdef WEIGHTED_REFEREE_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: expected pop pattern per cycle, and expected push/data one cycle after each pop
    logic [NUM_CH-1:0] exp_pop_q [$];
    logic [NUM_CH-1:0] exp_ch_q  [$];
    logic [DATA_W-1:0] exp_dat_q [$];
    logic [NUM_CH-1:0] prev_empty;
    logic              prev_stall;
    logic [DATA_W-1:0] last_data;

    // inputs as the DUT saw them at the edge that produced the current pop
    always @(posedge clk) begin
        prev_empty <= bus.src_empty;
        prev_stall <= |bus.dst_almost_full;
    end

    always @(negedge clk) begin
        logic [NUM_CH-1:0] ech;
        logic [DATA_W-1:0] ed;
        if (!rst_n) begin
            exp_ch_q.delete();
            exp_dat_q.delete();
            last_data = '0;
            check("push_in_reset", 32'(bus.push), 32'd0);
        end else begin
            if (exp_ch_q.size() > 0) begin
                ech = exp_ch_q.pop_front();
                ed  = exp_dat_q.pop_front();
                check("push", 32'(bus.push), 32'(ech));
                check("data_out", 32'(bus.data_out), 32'(ed));
                last_data = ed;
            end else begin
                check("push_idle", 32'(bus.push), 32'd0);
                check("data_hold", 32'(bus.data_out), 32'(last_data));
            end
            check("pop_onehot", 32'($countones(bus.pop) <= 1), 32'd1);
            check("pop_of_empty", 32'(bus.pop & prev_empty), 32'd0);
            if (prev_stall) check("pop_in_stall", 32'(bus.pop), 32'd0);
        end
        bus.data_in = DATA_W'($urandom);
        if (rst_n && (bus.pop != '0)) begin
            exp_ch_q.push_back(bus.pop);
            exp_dat_q.push_back(bus.data_in);
        end
    end

    task automatic run_pops(input string tag);
        logic [NUM_CH-1:0] e;
        while (exp_pop_q.size() > 0) begin
            e = exp_pop_q.pop_front();
            @(negedge clk);
            check(tag, 32'(bus.pop), 32'(e));
        end
    endtask

    task automatic push_wrr_round(input int w0, input int w1, input int w2, input int w3);
        for (int i = 0; i < w0; i++) exp_pop_q.push_back(4'b0001);
        for (int i = 0; i < w1; i++) exp_pop_q.push_back(4'b0010);
        for (int i = 0; i < w2; i++) exp_pop_q.push_back(4'b0100);
        for (int i = 0; i < w3; i++) exp_pop_q.push_back(4'b1000);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        last_data = '0;
        bus.src_empty       = 4'b0000;
        bus.src_almost_full = 4'b0000;
        bus.dst_almost_full = 4'b0000;
        bus.weights         = 16'h1111;
        bus.data_in         = '0;
        repeat (3) @(negedge clk);
        check("rst_pop", 32'(bus.pop), 32'd0);
        check("rst_push", 32'(bus.push), 32'd0);
        check("rst_data", 32'(bus.data_out), 32'd0);
`ifdef WEIGHTED_REFEREE_STATS_EN
        check("rst_count", 32'(grant_count[15:0]), 32'd0);
`endif
        #1 rst_n = 1'b1;

        // RR from reset: starts at channel 0 and wraps
        exp_pop_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        run_pops("rr_seq");

        // empty channels are skipped
        bus.src_empty = 4'b1010;
        exp_pop_q = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
        run_pops("rr_skip");

        // all empty: nothing popped, pointer held at channel 0
        bus.src_empty = 4'b1111;
        exp_pop_q = '{4'b0000, 4'b0000, 4'b0000};
        run_pops("all_empty");
        bus.src_empty = 4'b0000;
        exp_pop_q = '{4'b0010};
        run_pops("ptr_held");

        // 3-cycle destination backpressure, then resume at the next channel
        bus.dst_almost_full = 4'b0100;
        exp_pop_q = '{4'b0000, 4'b0000, 4'b0000};
        run_pops("stall");
        bus.dst_almost_full = 4'b0000;
        exp_pop_q = '{4'b0100, 4'b1000};
        run_pops("stall_resume");

        // weighted mode: weights ch3..ch0 = 1,2,3,4
        bus.weights         = 16'h1234;
        bus.src_almost_full = 4'b0001;
        push_wrr_round(4, 3, 2, 1);
        push_wrr_round(4, 3, 2, 1);
        run_pops("wrr");

        // a zero weight behaves as one
        bus.weights = 16'h1204;
        push_wrr_round(4, 1, 2, 1);
        run_pops("wrr_w0");

        // back to RR, pointer retained at channel 3
        bus.src_almost_full = 4'b0000;
        exp_pop_q = '{4'b0001, 4'b0010};
        run_pops("wrr_to_rr");

        // reset right after pop[1]: owed push dropped, restart at channel 0
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_pop", 32'(bus.pop), 32'd0);
        check("midrst_push", 32'(bus.push), 32'd0);
        #1 rst_n = 1'b1;
        exp_pop_q = '{4'b0001};
        run_pops("post_rst");

`ifdef WEIGHTED_REFEREE_STATS_EN
        bus.src_empty = 4'b1110;
        repeat (70000) @(negedge clk);
        check("count_sat", 32'(grant_count[15:0]), 32'hFFFF);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
